// File: rtl/pat_seq_pkg.sv
// Shared types and pattern-word field offsets for the pattern sequencer.
// A memory word is packed as {mask, exp, stim}, with stim in the low bits.
package pat_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_APPLY,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    function automatic int stim_lsb();
        return 0;
    endfunction

    function automatic int exp_lsb(input int in_w);
        return in_w;
    endfunction

    function automatic int mask_lsb(input int in_w, input int out_w);
        return in_w + out_w;
    endfunction

endpackage

// File: rtl/pat_seq_ctrl_cmp.sv
// Masked response compare with saturating mismatch counter, first-fail
// address capture and a sticky fail flag, cleared at the start of each run.
module pat_cmp #(
    parameter int OUT_W  = 2,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_capture,
    input  logic [OUT_W-1:0]  i_dut_out,
    input  logic [OUT_W-1:0]  i_exp,
    input  logic [OUT_W-1:0]  i_mask,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_fail,
    output logic [CNT_W-1:0]  o_cnt,
    output logic [ADDR_W-1:0] o_first_addr
);

    logic              w_mismatch;
    logic              r_fail;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_first_addr;

    assign w_mismatch = |((i_dut_out ^ i_exp) & ~i_mask);

    // r_fail is still low on the first mismatch of a run, so it gates the address capture
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fail       <= 1'b0;
            r_cnt        <= '0;
            r_first_addr <= '0;
        end else if (i_clear) begin
            r_fail       <= 1'b0;
            r_cnt        <= '0;
            r_first_addr <= '0;
        end else if (i_capture && w_mismatch) begin
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (!r_fail) begin
                r_first_addr <= i_addr;
                r_fail       <= 1'b1;
            end
        end
    end

    assign o_fail       = r_fail;
    assign o_cnt        = r_cnt;
    assign o_first_addr = r_first_addr;

endmodule

// File: rtl/pat_seq_ctrl.sv
// Pattern sequencer: fetches {mask, exp, stim} words, drives the stimulus,
// waits SETTLE cycles and hands the DUT response to the masked comparator.
module pat_seq_ctrl
    import pat_seq_pkg::*;
#(
    parameter int IN_W   = 1,
    parameter int OUT_W  = 2,
    parameter int ADDR_W = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_W:0]         num_pat,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_rd,
    input  logic [2*OUT_W+IN_W-1:0] mem_data,
    output logic [IN_W-1:0]         dut_in,
    input  logic [OUT_W-1:0]        dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    output logic [CNT_W-1:0]        mismatch_cnt,
    output logic [ADDR_W-1:0]       first_fail_addr
);

    localparam int STIM_L = stim_lsb();
    localparam int EXP_L  = exp_lsb(IN_W);
    localparam int MASK_L = mask_lsb(IN_W, OUT_W);
    localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_num;
    logic [WAIT_W-1:0] r_wait;
    logic [IN_W-1:0]   r_dut_in;
    logic [OUT_W-1:0]  r_exp;
    logic [OUT_W-1:0]  r_mask;
    logic              w_last;
    logic              w_wait_end;
    logic              w_clear;
    logic              w_capture;

    assign w_last     = ({1'b0, r_addr} == (r_num - 1'b1));
    assign w_wait_end = (r_wait == WAIT_W'(SETTLE - 1));
    assign w_clear    = (r_state == ST_IDLE) && start && (num_pat != '0);
    assign w_capture  = (r_state == ST_CAPTURE) && !abort;

    // Abort overrides every transition out of a non-idle state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (num_pat == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH:   w_next = ST_APPLY;
            ST_APPLY:   w_next = (SETTLE > 0) ? ST_WAIT : ST_CAPTURE;
            ST_WAIT:    w_next = w_wait_end ? ST_CAPTURE : ST_WAIT;
            ST_CAPTURE: w_next = w_last ? ST_DONE : ST_FETCH;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_num    <= '0;
            r_wait   <= '0;
            r_dut_in <= '0;
            r_exp    <= '0;
            r_mask   <= '0;
        end else begin
            r_state <= w_next;
            if (w_clear) begin
                r_addr <= '0;
                r_num  <= num_pat;
            end
            if ((r_state == ST_APPLY) && !abort) begin
                r_dut_in <= mem_data[STIM_L +: IN_W];
                r_exp    <= mem_data[EXP_L +: OUT_W];
                r_mask   <= mem_data[MASK_L +: OUT_W];
            end
            if (r_state == ST_APPLY) begin
                r_wait <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_capture && !w_last) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    pat_cmp #(
        .OUT_W  (OUT_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_cmp (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clear      (w_clear),
        .i_capture    (w_capture),
        .i_dut_out    (dut_out),
        .i_exp        (r_exp),
        .i_mask       (r_mask),
        .i_addr       (r_addr),
        .o_fail       (fail),
        .o_cnt        (mismatch_cnt),
        .o_first_addr (first_fail_addr)
    );

    assign mem_addr = r_addr;
    assign mem_rd   = (r_state == ST_FETCH);
    assign dut_in   = r_dut_in;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_pat_seq_ctrl.sv
// Directed bench for pat_seq_ctrl against a DUT with outputs tied to 2'b01,
// using a synchronous pattern memory model and a table of hand-computed runs.
module tb_pat_seq_ctrl;

    typedef struct {
        logic [4:0]  num;
        logic [15:0] stim;
        logic [31:0] expw;
        logic [31:0] maskw;
        int          cycles;
        logic [1:0]  cnt;
        logic        fail;
        logic [3:0]  ffa;
        logic        dutIn;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic       start;
    logic       abort;
    logic [4:0] numPat;
    logic [3:0] memAddr;
    logic       memRd;
    logic [4:0] memData;
    logic [0:0] dutIn;
    logic [1:0] dutOut;
    logic       busy;
    logic       done;
    logic       fail;
    logic [1:0] mismatchCnt;
    logic [3:0] firstFailAddr;

    logic [4:0] mem [16];
    int         checks = 0;
    int         errors = 0;
    int         rdTotal = 0;
    int         doneTotal = 0;
    vec_t       vecs [8];

    assign dutOut = 2'b01;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memRd) memData <= mem[memAddr];
    end

    always @(negedge clk) begin
        if (memRd) rdTotal++;
        if (done) doneTotal++;
    end

    pat_seq_ctrl #(
        .IN_W   (1),
        .OUT_W  (2),
        .ADDR_W (4),
        .SETTLE (1),
        .CNT_W  (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rstN),
        .start           (start),
        .abort           (abort),
        .num_pat         (numPat),
        .mem_addr        (memAddr),
        .mem_rd          (memRd),
        .mem_data        (memData),
        .dut_in          (dutIn),
        .dut_out         (dutOut),
        .busy            (busy),
        .done            (done),
        .fail            (fail),
        .mismatch_cnt    (mismatchCnt),
        .first_fail_addr (firstFailAddr)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic loadPatterns(input logic [15:0] stim, input logic [31:0] expw, input logic [31:0] maskw);
        for (int i = 0; i < 16; i++) begin
            mem[i] = {maskw[2*i +: 2], expw[2*i +: 2], stim[i]};
        end
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < 200);
    endtask

    task automatic pulseStart(input logic [4:0] n);
        @(negedge clk);
        numPat = n;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, output int cycles);
        loadPatterns(v.stim, v.expw, v.maskw);
        pulseStart(v.num);
        waitDone(cycles);
    endtask

    task automatic checkResults(input string tag, input logic [1:0] cnt, input logic fl,
                                input logic [3:0] ffa, input logic di);
        checkOutput({tag, " mismatchCnt"}, 32'(mismatchCnt), 32'(cnt));
        checkOutput({tag, " fail"}, 32'(fail), 32'(fl));
        checkOutput({tag, " firstFailAddr"}, 32'(firstFailAddr), 32'(ffa));
        checkOutput({tag, " dutIn"}, 32'(dutIn), 32'(di));
    endtask

    initial begin
        int cyc;
        int rd0;
        int d0;

        vecs[0] = '{5'd4,  16'h0005, 32'h0000_0055, 32'h0000_0000, 17, 2'd0, 1'b0, 4'd0, 1'b0};
        vecs[1] = '{5'd4,  16'h000A, 32'h0000_0075, 32'h0000_0000, 17, 2'd1, 1'b1, 4'd2, 1'b1};
        vecs[2] = '{5'd0,  16'hFFFF, 32'h0000_0000, 32'h0000_0000, 1,  2'd1, 1'b1, 4'd2, 1'b1};
        vecs[3] = '{5'd4,  16'h0003, 32'h0000_0075, 32'h0000_0020, 17, 2'd0, 1'b0, 4'd0, 1'b0};
        vecs[4] = '{5'd5,  16'h0010, 32'h0000_02AA, 32'h0000_0000, 21, 2'd3, 1'b1, 4'd0, 1'b1};
        vecs[5] = '{5'd1,  16'h0000, 32'h0000_0002, 32'h0000_0003, 5,  2'd0, 1'b0, 4'd0, 1'b0};
        vecs[6] = '{5'd3,  16'h0004, 32'h0000_0031, 32'h0000_0000, 13, 2'd2, 1'b1, 4'd1, 1'b1};
        vecs[7] = '{5'd16, 16'h8000, 32'h1555_5555, 32'h4000_0000, 65, 2'd0, 1'b0, 4'd0, 1'b1};

        rstN   = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        numPat = '0;
        loadPatterns(16'h0000, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset memRd", 32'(memRd), 32'd0);
        checkOutput("reset memAddr", 32'(memAddr), 32'd0);
        checkResults("reset", 2'd0, 1'b0, 4'd0, 1'b0);
        rstN = 1'b1;

        // abort while idle must leave the sequencer idle
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("idle abort busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            rd0 = rdTotal;
            d0  = doneTotal;
            applyStimulus(vecs[i], cyc);
            checkOutput($sformatf("v%0d doneCycle", i), 32'(cyc), 32'(vecs[i].cycles));
            checkResults($sformatf("v%0d", i), vecs[i].cnt, vecs[i].fail, vecs[i].ffa, vecs[i].dutIn);
            @(negedge clk);
            checkOutput($sformatf("v%0d busyAfter", i), 32'(busy), 32'd0);
            checkOutput($sformatf("v%0d memRdCount", i), 32'(rdTotal - rd0), 32'(vecs[i].num));
            checkOutput($sformatf("v%0d donePulses", i), 32'(doneTotal - d0), 32'd1);
        end

        // abort in the WAIT state of pattern 1; pattern 0 (exp 11) already failed
        loadPatterns(16'h000A, 32'h0000_0057, 32'h0);
        d0 = doneTotal;
        pulseStart(5'd4);
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkResults("abort hold", 2'd1, 1'b1, 4'd0, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("abort donePulses", 32'(doneTotal - d0), 32'd0);

        // restart completes normally; a start pulse mid-run is ignored
        rd0 = rdTotal;
        pulseStart(5'd4);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) begin
                numPat = 5'd1;
                start  = 1'b1;
            end else if (cyc == 6) begin
                start = 1'b0;
            end
        end while (!done && cyc < 200);
        start = 1'b0;
        checkOutput("restart doneCycle", 32'(cyc), 32'd17);
        checkResults("restart", 2'd1, 1'b1, 4'd0, 1'b1);
        @(negedge clk);
        checkOutput("restart memRdCount", 32'(rdTotal - rd0), 32'd4);

        // synchronous reset in the middle of a run
        d0 = doneTotal;
        pulseStart(5'd4);
        repeat (6) @(negedge clk);
        rstN = 1'b0;
        @(posedge clk);
        #1 rstN = 1'b1;
        @(negedge clk);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset memRd", 32'(memRd), 32'd0);
        checkOutput("midreset memAddr", 32'(memAddr), 32'd0);
        checkResults("midreset", 2'd0, 1'b0, 4'd0, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("midreset donePulses", 32'(doneTotal - d0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pat_seq_ctrl.md
# pat_seq_ctrl

Pattern sequencer that drives stored test patterns into a device under test (DUT) and checks the DUT's responses. It fetches each stimulus/expected word from a synchronous pattern memory, applies the stimulus to the DUT inputs and waits a programmable settle time. It then compares the DUT outputs against the expected value under an X-mask, counting mismatches and recording the first failing address. It sits between the pattern store produced by pattern generation and the netlist under test, and gives the fault-simulation bench a cycle-accurate hardware pass/fail check.

## Interface
Parameters:
- IN_W, 1: DUT input width (stimulus field).
- OUT_W, 2: DUT output width (expected and mask fields).
- ADDR_W, 4: pattern memory address width; at most 2^ADDR_W patterns.
- SETTLE, 1: wait cycles between apply and capture; 0 is legal.
- CNT_W, 8: mismatch counter width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  terminate the run; highest priority after reset.
- num_pat  in  ADDR_W+1  number of patterns to run, sampled on start.
- mem_addr  out  ADDR_W  pattern memory read address.
- mem_rd  out  1  memory read enable.
- mem_data  in  2*OUT_W+IN_W  read data {mask, exp, stim}, valid the cycle after mem_rd.
- dut_in  out  IN_W  registered stimulus to the DUT.
- dut_out  in  OUT_W  DUT response.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run completes normally.
- fail  out  1  sticky; at least one mismatch occurred in the current or last run.
- mismatch_cnt  out  CNT_W  saturating mismatch count.
- first_fail_addr  out  ADDR_W  address of the first mismatching pattern.

## Operation
- States: IDLE, FETCH, APPLY, WAIT, CAPTURE, DONE.
- IDLE:
  - With start=1 and num_pat=0, go to DONE.
  - With start=1 and num_pat>0, clear mismatch_cnt, fail and first_fail_addr, set addr=0, latch num_pat, and go to FETCH.
- FETCH: mem_rd=1, mem_addr=addr; go to APPLY.
- APPLY: register dut_in <= mem_data stim field and latch exp and mask. Go to WAIT if SETTLE>0, else go to CAPTURE.
- WAIT: count SETTLE cycles, then go to CAPTURE.
- CAPTURE:
  - A mismatch is ((dut_out ^ exp) & ~mask) != 0.
  - On a mismatch: increment mismatch_cnt, saturating at 2^CNT_W-1.
  - On the first mismatch of the run: record first_fail_addr=addr and set fail=1.
  - If addr==num_pat-1, go to DONE; else addr++ and go to FETCH.
- DONE: done=1 for one cycle, then go to IDLE.
- start while busy: ignored.
- abort=1 in any non-IDLE state: go to IDLE next cycle, done not pulsed. Counters and dut_in hold their values.
- abort in IDLE: no effect.
- Bits with mask=1 never cause a mismatch; an all-ones mask always passes.

## Timing
- Reset values:
  - State IDLE.
  - mem_addr=0, mem_rd=0, dut_in=0.
  - busy=0, done=0, fail=0.
  - mismatch_cnt=0, first_fail_addr=0.
- Reset mid-run behaves the same as reset from idle; no done pulse.
- Per-pattern cost: SETTLE+3 cycles.
- done is asserted N*(SETTLE+3)+1 cycles after the edge that samples start. For num_pat=0, it is asserted 1 cycle after that edge.
- dut_in changes only on the edge that leaves APPLY. dut_out is sampled on the edge that leaves CAPTURE.
- mismatch_cnt and fail are updated on that same edge and are stable when done is high.
- busy falls on the edge that leaves DONE. A new start is accepted the cycle after done.

## Structure
- Package pat_seq_pkg holds:
  - the state enum;
  - the field offset constants STIM_LSB=0, EXP_LSB=IN_W, MASK_LSB=IN_W+OUT_W as parameterised functions.
- One sub-module, pat_cmp: the masked compare, saturating counter, first-fail capture and sticky fail, enabled by a capture strobe.
- The FSM and address counter stay in pat_seq_ctrl.

## Test plan
All scenarios use a DUT with outputs tied {a,o}=2'b01 (tie-low and tie-high), OUT_W=2, SETTLE=1.
- 4 patterns, all exp=01, mask=00 -> done at cycle 17, mismatch_cnt=0, fail=0.
- 4 patterns, pattern 2 exp=11 -> mismatch_cnt=1, first_fail_addr=2, fail=1.
- Same stimulus but pattern 2 mask=10 -> mismatch_cnt=0.
- num_pat=0 -> done one cycle after start, mem_rd never asserted.
- CNT_W=2, 5 patterns all exp=10 -> mismatch_cnt saturates at 3, first_fail_addr=0.
- abort during WAIT of pattern 1 -> IDLE next cycle, no done pulse; a restart then completes all 4 patterns normally.
